// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the iterative ALU.
// Base codes are the 4-bit core ALU encoding; M codes are RV32M funct3.
package alu_pkg;
   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b1000;
   localparam logic [3:0] OP_SLL   = 4'b0001;
   localparam logic [3:0] OP_SLT   = 4'b0010;
   localparam logic [3:0] OP_SLTU  = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_SRL   = 4'b0101;
   localparam logic [3:0] OP_SRA   = 4'b1101;
   localparam logic [3:0] OP_OR    = 4'b0110;
   localparam logic [3:0] OP_AND   = 4'b0111;
   localparam logic [3:0] OP_PASSB = 4'b1111;

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } alu_state_e;
endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M engine: shift-add multiply and restoring divide over
// magnitudes in one shared 2*XLEN accumulator, sign fix applied on the output.
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

   logic              is_mul_in, a_sgn, b_sgn, neg_a, neg_b;
   logic [XLEN-1:0]   mag_a, mag_b;

   logic              busy_q, is_mul_q, neg_a_q, neg_b_q;
   logic [2:0]        op_q;
   logic [CW-1:0]     cnt_q;
   logic [XLEN-1:0]   mag_q;
   logic [2*XLEN-1:0] acc_q, acc_next, prod;
   logic [XLEN:0]     mul_sum, div_shift;
   logic [XLEN+1:0]   div_diff;
   logic [XLEN-1:0]   quo_s, rem_s;

   always_comb begin
      is_mul_in = (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_MULHU);
      a_sgn     = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
      b_sgn     = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
      neg_a     = a_sgn && operand_a[XLEN-1];
      neg_b     = b_sgn && operand_b[XLEN-1];
      mag_a     = neg_a ? -operand_a : operand_a;
      mag_b     = neg_b ? -operand_b : operand_b;
   end

   // Multiply: acc = {partial high, multiplier shifting out}.
   // Divide:   acc = {partial remainder, dividend shifting into quotient}.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : {(XLEN+1){1'b0}});
      div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, mag_q};
      if (is_mul_q)
         acc_next = {mul_sum, acc_q[XLEN-1:1]};
      else if (div_diff[XLEN+1])
         acc_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else
         acc_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         is_mul_q <= 1'b0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         op_q     <= '0;
         mag_q    <= '0;
         acc_q    <= '0;
      end else if (flush) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else if (start) begin
         busy_q   <= 1'b1;
         cnt_q    <= '0;
         is_mul_q <= is_mul_in;
         neg_a_q  <= neg_a;
         neg_b_q  <= neg_b;
         op_q     <= op;
         mag_q    <= is_mul_in ? mag_a : mag_b;
         acc_q    <= {{XLEN{1'b0}}, (is_mul_in ? mag_b : mag_a)};
      end else if (busy_q) begin
         acc_q <= acc_next;
         cnt_q <= cnt_q + CW'(1);
         if (cnt_q == CNT_LAST) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
         end
      end
   end

   assign done = busy_q && (cnt_q == CNT_LAST);

   always_comb begin
      prod  = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
      quo_s = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem_s = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      case (op_q)
         MD_MUL:                       result = prod[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:              result = quo_s;
         default:                      result = rem_s;
      endcase
   end
endmodule

// File: rtl/alu_iter.sv
// Execute-stage ALU: single-cycle RV32I base ops plus optional iterative RV32M
// path. The core stalls while o_ready is low and takes the result on o_valid.
module alu_iter
   import alu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter bit MD_EN = 1'b1
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_flush,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [4:0]      i_op,
   input  logic [XLEN-1:0] i_operand_a,
   input  logic [XLEN-1:0] i_operand_b,
   output logic            o_valid,
   output logic [XLEN-1:0] o_result,
   output logic [1:0]      o_state
);
   localparam int SW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   alu_state_e      state_q, state_d;
   logic            accept, is_m, md_is_div, div_zero, div_ovf, special, go_iter;
   logic            md_start, md_done, load_quick, load_md;
   logic [2:0]      f3;
   logic [SW-1:0]   shamt;
   logic [XLEN-1:0] base_result, special_result, quick_result, md_result;

   always_comb begin
      shamt       = i_operand_b[SW-1:0];
      base_result = '0;
      case (i_op[3:0])
         OP_ADD:   base_result = i_operand_a + i_operand_b;
         OP_SUB:   base_result = i_operand_a - i_operand_b;
         OP_SLL:   base_result = i_operand_a << shamt;
         OP_SLT:   base_result = {{(XLEN-1){1'b0}}, ($signed(i_operand_a) < $signed(i_operand_b))};
         OP_SLTU:  base_result = {{(XLEN-1){1'b0}}, (i_operand_a < i_operand_b)};
         OP_XOR:   base_result = i_operand_a ^ i_operand_b;
         OP_SRL:   base_result = i_operand_a >> shamt;
         OP_SRA:   base_result = $unsigned($signed(i_operand_a) >>> shamt);
         OP_OR:    base_result = i_operand_a | i_operand_b;
         OP_AND:   base_result = i_operand_a & i_operand_b;
         OP_PASSB: base_result = i_operand_b;
         default:  base_result = '0;
      endcase
   end

   // Divide corner cases are answered directly so they keep base latency.
   always_comb begin
      f3        = i_op[2:0];
      is_m      = i_op[4];
      md_is_div = (f3 == MD_DIV) || (f3 == MD_DIVU) || (f3 == MD_REM) || (f3 == MD_REMU);
      div_zero  = (i_operand_b == '0);
      div_ovf   = ((f3 == MD_DIV) || (f3 == MD_REM)) &&
                  (i_operand_a == MOST_NEG) && (i_operand_b == '1);
      special   = MD_EN && md_is_div && (div_zero || div_ovf);
      if (div_zero)
         special_result = ((f3 == MD_REM) || (f3 == MD_REMU)) ? i_operand_a : '1;
      else
         special_result = ((f3 == MD_REM) || (f3 == MD_REMU)) ? '0 : i_operand_a;
      if (!is_m)
         quick_result = base_result;
      else if (special)
         quick_result = special_result;
      else
         quick_result = '0;
      go_iter = MD_EN && is_m && !special;
   end

   // Handshake: an op is taken on any edge where i_valid && o_ready && !i_flush;
   // o_ready is high only in IDLE/DONE and never while i_reset is asserted.
   assign o_ready  = ((state_q == IDLE) || (state_q == DONE)) && !i_reset;
   assign accept   = i_valid && o_ready && !i_flush;
   assign md_start = accept && go_iter;

   always_comb begin
      state_d    = state_q;
      load_quick = 1'b0;
      load_md    = 1'b0;
      if (i_flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (accept) begin
                  state_d    = go_iter ? ITER : DONE;
                  load_quick = !go_iter;
               end else begin
                  state_d = IDLE;
               end
            end
            ITER:    state_d = md_done ? FIX : ITER;
            FIX: begin
               state_d = DONE;
               load_md = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= IDLE;
         o_result <= '0;
      end else begin
         state_q <= state_d;
         if (load_quick)
            o_result <= quick_result;
         else if (load_md)
            o_result <= md_result;
      end
   end

   assign o_valid = (state_q == DONE);
   assign o_state = state_q;

   generate
      if (MD_EN) begin : g_md
         muldiv_iter #(.XLEN(XLEN)) u_muldiv (
            .clk       (i_clk),
            .reset     (i_reset),
            .flush     (i_flush),
            .start     (md_start),
            .op        (f3),
            .operand_a (i_operand_a),
            .operand_b (i_operand_b),
            .done      (md_done),
            .result    (md_result)
         );
      end else begin : g_no_md
         assign md_done   = 1'b0;
         assign md_result = '0;
      end
   endgenerate
endmodule
